leitor_vga: RTL
===============

# leitor_vga

Downstream display stage of the coprocessor: scans the frame RAM written by the copy and zoom stages and drives a 640x480@60 Hz VGA output. Generates the sync counters and read addresses for the frame RAM, and centres a parameterised grayscale image window on a black background. The sync timing is free-running and independent of the image producers. The `enable` input blanks the image until the writer reports `done`.

## Interface
Parameters:
- `IMG_W`, 320: image width in pixels
- `IMG_H`, 240: image height in pixels
- `IMG_X0`, 160: first active column of the window
- `IMG_Y0`, 120: first active line of the window
- `H_ACTIVE/H_FP/H_SYNC/H_BP`, 640/16/96/48: horizontal timing; `H_TOTAL` = 800
- `V_ACTIVE/V_FP/V_SYNC/V_BP`, 480/10/2/33: vertical timing; `V_TOTAL` = 525

Ports:
- `clk`, in, 1: 25 MHz pixel clock; one pixel per cycle
- `reset`, in, 1: asynchronous, active-high
- `enable`, in, 1: image shown when high; tie to the writer's `done`
- `ram_rdaddr`, out, 19: frame RAM read address, registered
- `ram_q`, in, 8: frame RAM data; valid one clock after `ram_rdaddr` is sampled
- `vga_r`, `vga_g`, `vga_b`, out, 8 each: grayscale pixel, same value on all three
- `vga_hsync`, out, 1: active-low
- `vga_vsync`, out, 1: active-low
- `vga_blank_n`, out, 1: high during the active 640x480 area
- `vga_sync_n`, out, 1: constant 0
- `frame_start`, out, 1: one-cycle pulse aligned with output pixel (0,0)

## Operation
- `h_cnt` runs 0..799 and wraps to 0. `v_cnt` increments when `h_cnt` wraps, runs 0..524, and wraps to 0.
- Active area: h < 640 and v < 480.
- HSYNC is low for h in 656..751. VSYNC is low for v in 490..491.
- Window: `IMG_X0` ≤ h < `IMG_X0`+`IMG_W` and `IMG_Y0` ≤ v < `IMG_Y0`+`IMG_H`.
- Inside the window, `ram_rdaddr` = (v−`IMG_Y0`)·`IMG_W` + (h−`IMG_X0`), computed modulo 2^19.
- The address is kept incrementally with a line-base register plus a column offset. No multiplier is allowed.
- Outside the window, `ram_rdaddr` holds its last value.
- Pixel value is `ram_q` when the delayed in-window flag is 1 and `enable` is 1. Otherwise the pixel value is 0.
- Outside the active area the pixel value is forced to 0, regardless of window and `enable`.
- `enable` is sampled in the output stage. A change in `enable` takes effect on the next output pixel. A mid-frame change is allowed and produces a partial image; no tearing protection is provided.
- Reset values: `h_cnt`=`v_cnt`=0, `ram_rdaddr`=0, rgb=0, `vga_hsync`=1, `vga_vsync`=1, `vga_blank_n`=0, `frame_start`=0, all delay-pipeline registers cleared.
- Reset asserted mid-frame: every output takes its reset value immediately (asynchronously). After release, scanning restarts at (0,0).

## Timing
- Pipeline:
  - Edge E0: the counters hold (h,v).
  - Edge E1: `ram_rdaddr` for (h,v) is registered.
  - Edge E2: the RAM samples the address; `ram_q` is valid after E2.
  - Edge E3: rgb, syncs, `vga_blank_n` and `frame_start` for (h,v) are registered.
- Fixed output latency is 3 clocks from counter to pins.
- hsync, vsync, blank and window flags pass through the same 3-stage delay as the data, so sync/data relationships equal the counter-domain relationships.
- `frame_start` is high exactly one clock per frame, when the outputs carry (0,0). No pulse occurs during the first 3 clocks after reset release.
- Frame period: 800·525 = 420000 clocks. Line period: 800 clocks.
- There is no handshake with the RAM: one read per clock, every clock, and the RAM read port must never stall.

## Test plan
- Reset, then release; count clocks -> `frame_start` pulses exactly 420000 clocks apart. `vga_hsync` is low for 96 clocks every 800. `vga_vsync` is low for 1600 clocks per frame.
- RAM model returns data = addr[7:0], `enable`=1 -> output pixel at screen (160,120) = 0x00, at (161,120) = 0x01, at (160,121) = 320 mod 256 = 0x40. Pixels at (159,120) and (480,120) = 0.
- Trace `ram_rdaddr` over a full frame -> first in-window address 0, last 76799, strictly +1 per in-window pixel. The address holds outside the window.
- `enable`=0 with nonzero RAM data -> rgb=0 for the whole frame; sync and blank timing unchanged.
- Assert `reset` at v=300, h=400 -> all outputs go to reset values without waiting for a clock edge. After release, the first `frame_start` arrives 3 clocks later at (0,0).
- Check output at h=640..799 and v=480..524 -> `vga_blank_n`=0 and rgb=0, even when the window parameters are set to extend past the active area.

Source files
------------

// File: rtl/leitor_vga.sv
// VGA scan-out stage: free-running sync counters, frame RAM read addressing and a
// 3-stage pipeline that keeps syncs, blanking and grayscale pixel data aligned at the pins.
module leitor_vga #(
  parameter int unsigned IMG_W    = 320,
  parameter int unsigned IMG_H    = 240,
  parameter int unsigned IMG_X0   = 160,
  parameter int unsigned IMG_Y0   = 120,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [18:0] ram_rdaddr,
  input  logic [7:0]  ram_q,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic        frame_start
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [9:0]  h_cnt, v_cnt;
  logic [31:0] h_i, v_i;
  logic [18:0] line_base;
  logic [18:0] col;
  logic        h_last, v_last;
  logic        act, hs_on, vs_on, win, first;
  // Flag bundle carried alongside the RAM read: {first, act, hs_on, vs_on, win}
  logic [4:0]  s1_flags, s2_flags;
  logic [7:0]  pixel;

  assign h_i    = {22'd0, h_cnt};
  assign v_i    = {22'd0, v_cnt};
  assign h_last = (h_i == H_TOTAL - 1);
  assign v_last = (v_i == V_TOTAL - 1);

  assign act   = (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
  assign hs_on = (h_i >= H_ACTIVE + H_FP) && (h_i < H_ACTIVE + H_FP + H_SYNC);
  assign vs_on = (v_i >= V_ACTIVE + V_FP) && (v_i < V_ACTIVE + V_FP + V_SYNC);
  assign win   = (h_i >= IMG_X0) && (h_i < IMG_X0 + IMG_W) &&
                 (v_i >= IMG_Y0) && (v_i < IMG_Y0 + IMG_H);
  assign first = (h_cnt == 10'd0) && (v_cnt == 10'd0);
  assign col   = 19'(h_i - IMG_X0);

  // line_base tracks (v - IMG_Y0) * IMG_W by adding IMG_W once per window line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      line_base <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      if (v_last) begin
        v_cnt     <= '0;
        line_base <= '0;
      end else begin
        v_cnt <= v_cnt + 10'd1;
        if (v_i >= IMG_Y0) line_base <= line_base + 19'(IMG_W);
      end
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_rdaddr <= '0;
      s1_flags   <= '0;
      s2_flags   <= '0;
    end else begin
      if (win) ram_rdaddr <= line_base + col;
      s1_flags <= {first, act, hs_on, vs_on, win};
      s2_flags <= s1_flags;
    end
  end

  // ram_q here belongs to the same pixel as s2_flags; blanking overrides the window.
  assign pixel = (s2_flags[3] && s2_flags[0] && enable) ? ram_q : 8'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= pixel;
      vga_g       <= pixel;
      vga_b       <= pixel;
      vga_hsync   <= ~s2_flags[2];
      vga_vsync   <= ~s2_flags[1];
      vga_blank_n <= s2_flags[3];
      frame_start <= s2_flags[4];
    end
  end

  assign vga_sync_n = 1'b0;
endmodule
